// File: rtl/risc_pkg.sv
// Shared definitions for the 16-bit RISC execute path: datapath widths and ALU opcodes.
package risc_pkg;
  localparam int DATA_W = 16;
  localparam int OP_W   = 3;
  localparam int TAG_W  = 4;

  localparam logic [OP_W-1:0] ALU_OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] ALU_OP_SUB = 3'd1;
  localparam logic [OP_W-1:0] ALU_OP_INV = 3'd2;
  localparam logic [OP_W-1:0] ALU_OP_SHL = 3'd3;
  localparam logic [OP_W-1:0] ALU_OP_SHR = 3'd4;
  localparam logic [OP_W-1:0] ALU_OP_AND = 3'd5;
  localparam logic [OP_W-1:0] ALU_OP_OR  = 3'd6;
  localparam logic [OP_W-1:0] ALU_OP_SLT = 3'd7;
endpackage

// File: rtl/alu_issue_unit_if.sv
// Request/response bundle between decode, the ALU issue unit and writeback.
// Handshake: a transfer happens on a rising edge where valid && ready; valid never waits on ready, ready never looks at valid.
interface alu_issue_if #(
  parameter int DATA_W = risc_pkg::DATA_W,
  parameter int OP_W   = risc_pkg::OP_W,
  parameter int TAG_W  = risc_pkg::TAG_W
) ();
  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;
  logic [OP_W-1:0]   req_op;
  logic [TAG_W-1:0]  req_tag;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_zero;
  logic [TAG_W-1:0]  rsp_tag;

  modport slave (
    input  req_valid, req_a, req_b, req_op, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_zero, rsp_tag
  );

  modport master (
    output req_valid, req_a, req_b, req_op, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_zero, rsp_tag
  );
endinterface

// File: rtl/alu.sv
// Existing combinational 16-bit ALU with zero flag; SLT is a signed compare.
module alu
  import risc_pkg::*;
(
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [OP_W-1:0]   ALU_Sel,
  output logic [DATA_W-1:0] ALU_Out,
  output logic              ZF
);
  always_comb begin
    ALU_Out = '0;
    case (ALU_Sel)
      ALU_OP_ADD: ALU_Out = A + B;
      ALU_OP_SUB: ALU_Out = A - B;
      ALU_OP_INV: ALU_Out = ~A;
      ALU_OP_SHL: ALU_Out = A << B[3:0];
      ALU_OP_SHR: ALU_Out = A >> B[3:0];
      ALU_OP_AND: ALU_Out = A & B;
      ALU_OP_OR:  ALU_Out = A | B;
      ALU_OP_SLT: ALU_Out = {{(DATA_W-1){1'b0}}, ($signed(A) < $signed(B))};
      default:    ALU_Out = '0;
    endcase
  end

  assign ZF = (ALU_Out == '0);
endmodule

// File: rtl/rsp_fifo2.sv
// Two-entry result buffer; head is shown combinationally and reads as zero when empty.
module rsp_fifo2 #(
  parameter int W = 21
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         rd_valid,
  output logic [1:0]   count
);
  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_rd;

  assign rd_valid = (count != 2'd0);
  assign do_rd    = rd_en && rd_valid;
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

  // The writer guarantees room (not full, or a read on the same edge), so wr_en is never blocked here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_rd) rd_ptr <= ~rd_ptr;
      if (wr_en && !do_rd)      count <= count + 2'd1;
      else if (!wr_en && do_rd) count <= count - 2'd1;
    end
  end
endmodule

// File: rtl/alu_issue_unit.sv
// Issue stage in front of the ALU: registers one request, evaluates it and queues {result, zero, tag} for writeback.
module alu_issue_unit #(
  parameter int DATA_W = risc_pkg::DATA_W,
  parameter int OP_W   = risc_pkg::OP_W,
  parameter int TAG_W  = risc_pkg::TAG_W
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_issue_if.slave          bus,
  output logic [15:0]         issue_count,
  output logic [1:0]          buf_count
);
  localparam int DEPTH = 2;
  localparam int RSP_W = DATA_W + 1 + TAG_W;

  logic              issue_valid;
  logic [DATA_W-1:0] issue_a;
  logic [DATA_W-1:0] issue_b;
  logic [OP_W-1:0]   issue_op;
  logic [TAG_W-1:0]  issue_tag;
  logic [DATA_W-1:0] alu_out;
  logic              alu_zf;
  logic              room;
  logic              accept;
  logic              buf_wr;
  logic [RSP_W-1:0]  head;

  // A full buffer still has room when the consumer drains the head on the same edge.
  assign room          = (buf_count != 2'(DEPTH)) || bus.rsp_ready;
  assign bus.req_ready = rst_n && (!issue_valid || room);
  assign accept        = bus.req_valid && bus.req_ready;
  assign buf_wr        = issue_valid && room;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      issue_valid <= 1'b0;
      issue_a     <= '0;
      issue_b     <= '0;
      issue_op    <= '0;
      issue_tag   <= '0;
      issue_count <= 16'd0;
    end else begin
      if (accept) begin
        issue_valid <= 1'b1;
        issue_a     <= bus.req_a;
        issue_b     <= bus.req_b;
        issue_op    <= bus.req_op;
        issue_tag   <= bus.req_tag;
      end else if (buf_wr) begin
        issue_valid <= 1'b0;
      end
      if (buf_wr) issue_count <= issue_count + 16'd1;
    end
  end

  alu u_alu (
    .A       (issue_a),
    .B       (issue_b),
    .ALU_Sel (issue_op),
    .ALU_Out (alu_out),
    .ZF      (alu_zf)
  );

  rsp_fifo2 #(.W(RSP_W)) u_rsp_fifo2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (buf_wr),
    .wr_data  ({alu_out, alu_zf, issue_tag}),
    .rd_en    (bus.rsp_ready),
    .rd_data  (head),
    .rd_valid (bus.rsp_valid),
    .count    (buf_count)
  );

  assign {bus.rsp_data, bus.rsp_zero, bus.rsp_tag} = head;
endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit: hand-computed results, an in-order expected queue and edge-case checks.
module tb_alu_issue_unit;
  import risc_pkg::*;

  localparam int W = DATA_W + 1 + TAG_W;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] issue_count;
  logic [1:0]  buf_count;
  int          checks = 0;
  int          errors = 0;
  int          rsp_seen = 0;
  int          waited;
  int          r0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] cur_exp;
  logic [W-1:0] exp_item;

  logic [15:0] sweep_d [8] = '{16'h800B, 16'h8005, 16'h7FF7, 16'h0040,
                               16'h1001, 16'h0000, 16'h800B, 16'h0001};
  logic        sweep_z [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  alu_issue_if bus ();

  alu_issue_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .issue_count (issue_count),
    .buf_count   (buf_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // scoreboard: accepted requests push their hand-computed result, drained results pop in order
  always @(negedge clk) begin
    if (rst_n && bus.req_valid && bus.req_ready) exp_q.push_back(cur_exp);
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      rsp_seen++;
      check("rsp_expected_present", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        exp_item = exp_q.pop_front();
        check("rsp_payload", 32'({bus.rsp_data, bus.rsp_zero, bus.rsp_tag}), 32'(exp_item));
      end
    end
  end

  // driver: present one request (called just after a rising edge), hold it until accepted
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                      input logic [3:0] tag, input logic [15:0] ed, input logic ez,
                      output int n);
    logic acc;
    bus.req_valid = 1'b1;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_op    = op;
    bus.req_tag   = tag;
    cur_exp       = {ed, ez, tag};
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 20) begin
      #1;
      acc = bus.req_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check("send_accepted", 32'(acc), 32'd1);
    bus.req_valid = 1'b0;
  endtask

  task automatic set_req(input logic [3:0] tag, input logic [15:0] ed);
    bus.req_valid = 1'b1;
    bus.req_a     = 16'(tag);
    bus.req_b     = 16'h0010;
    bus.req_op    = ALU_OP_ADD;
    bus.req_tag   = tag;
    cur_exp       = {ed, 1'b0, tag};
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_a     = 16'h1234;
    bus.req_b     = 16'h0001;
    bus.req_op    = ALU_OP_ADD;
    bus.req_tag   = 4'hF;
    bus.rsp_ready = 1'b1;
    cur_exp       = '0;

    // reset held 3 cycles with a request pending
    repeat (3) begin
      @(negedge clk);
      check("rst_req_ready", 32'(bus.req_ready), 32'd0);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst_issue_count", 32'(issue_count), 32'd0);
    end
    check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    check("rst_rsp_tag", 32'(bus.rsp_tag), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.req_valid = 1'b0;
    #1 check("post_rst_req_ready", 32'(bus.req_ready), 32'd1);

    // zero flag
    send(16'h8008, 16'h8008, ALU_OP_SUB, 4'd5, 16'h0000, 1'b1, waited);
    @(posedge clk); @(negedge clk);
    check("zf_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("zf_rsp_data", 32'(bus.rsp_data), 32'd0);
    check("zf_rsp_zero", 32'(bus.rsp_zero), 32'd1);
    check("zf_rsp_tag", 32'(bus.rsp_tag), 32'd5);
    @(posedge clk); #1;

    // nonzero result
    send(16'd5, 16'd3, ALU_OP_SUB, 4'd2, 16'd2, 1'b0, waited);
    @(posedge clk); @(negedge clk);
    check("nz_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("nz_rsp_data", 32'(bus.rsp_data), 32'd2);
    check("nz_rsp_zero", 32'(bus.rsp_zero), 32'd0);
    check("nz_rsp_tag", 32'(bus.rsp_tag), 32'd2);
    @(posedge clk); #1;

    // op sweep, A=0x8008 B=3, back to back
    for (int i = 0; i < 8; i++) begin
      send(16'h8008, 16'h0003, 3'(i), 4'(i), sweep_d[i], sweep_z[i], waited);
      check("sweep_one_cycle_accept", 32'(waited), 32'd1);
    end
    repeat (4) @(posedge clk);
    #1 check("sweep_issue_count", 32'(issue_count), 32'd10);

    // backpressure: only three requests fit, then release and drain at one per cycle
    bus.rsp_ready = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      send(16'(t), 16'h0010, ALU_OP_ADD, 4'(t), 16'(t) + 16'h0010, 1'b0, waited);
      check("bp_accept", 32'(waited), 32'd1);
    end
    set_req(4'd4, 16'h0014);
    repeat (3) begin
      @(negedge clk);
      check("bp_req_ready", 32'(bus.req_ready), 32'd0);
      check("bp_buf_count", 32'(buf_count), 32'd2);
    end
    check("bp_issue_count", 32'(issue_count), 32'd12);
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check("bp_drain_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp_drain_tag", 32'(bus.rsp_tag), 32'(i));
      if (i <= 2) check("full_rw_count", 32'(buf_count), 32'd2);
      if (i == 1) check("full_rd_req_ready", 32'(bus.req_ready), 32'd1);
      if (i == 5) check("bp_issue_count_end", 32'(issue_count), 32'd15);
      @(posedge clk); #1;
      if (i == 1) set_req(4'd5, 16'h0015);
      if (i == 2) bus.req_valid = 1'b0;
    end

    // throughput with a ready consumer
    r0 = rsp_seen;
    for (int k = 0; k < 6; k++) begin
      send(16'(6 + k), 16'h0100, ALU_OP_OR, 4'(6 + k), 16'h0100 | 16'(6 + k), 1'b0, waited);
      check("tput_one_cycle_accept", 32'(waited), 32'd1);
    end
    repeat (3) @(posedge clk);
    #1 check("tput_rsp_count", 32'(rsp_seen - r0), 32'd6);
    check("tput_issue_count", 32'(issue_count), 32'd21);

    // reset mid-stream with two buffered and one in issue
    bus.rsp_ready = 1'b0;
    for (int t = 12; t <= 14; t++)
      send(16'(t), 16'h0010, ALU_OP_ADD, 4'(t), 16'(t) + 16'h0010, 1'b0, waited);
    set_req(4'd15, 16'h001F);
    @(negedge clk);
    check("mid_buf_full", 32'(buf_count), 32'd2);
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("mid_rst_issue_count", 32'(issue_count), 32'd0);
    check("mid_rst_buf_count", 32'(buf_count), 32'd0);
    check("mid_rst_rsp_tag", 32'(bus.rsp_tag), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("mid_rst_no_stale", 32'(bus.rsp_valid), 32'd0);
    end
    @(posedge clk); #1;
    r0 = rsp_seen;
    send(16'd7, 16'd7, ALU_OP_SUB, 4'd9, 16'd0, 1'b1, waited);
    repeat (3) @(posedge clk);
    #1 check("post_rst_rsp_count", 32'(rsp_seen - r0), 32'd1);
    check("post_rst_issue_count", 32'(issue_count), 32'd1);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_issue_unit.md
Name: alu_issue_unit

Overview:
- Initiator-side wrapper for the existing combinational `alu` (ports ALU_Out, ZF, A, B, ALU_Sel).
- Accepts operation requests over a valid/ready handshake and registers operands into an issue stage.
- Drives the `alu` and captures each result plus zero flag into a 2-entry result buffer drained by a valid/ready consumer.
- Sits between decode and writeback in the 16-bit RISC execute path.

Parameters:
- DATA_W, 16, operand/result width; must match `alu`.
- OP_W, 3, ALU_Sel width.
- TAG_W, 4, request tag carried unchanged to the result (destination register id).
- DEPTH, 2, result buffer entries; fixed at 2 (pointer logic is 1 bit).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  issue stage can accept.
- req_a  input  DATA_W  operand A.
- req_b  input  DATA_W  operand B.
- req_op  input  OP_W  ALU_Sel value.
- req_tag  input  TAG_W  request tag.
- rsp_valid  output  1  result buffer non-empty.
- rsp_ready  input  1  consumer accepts head result.
- rsp_data  output  DATA_W  head result (ALU_Out).
- rsp_zero  output  1  head result zero flag (ZF).
- rsp_tag  output  TAG_W  head result tag.
- issue_count  output  16  number of results written into buffer since reset; wraps 0xFFFF->0x0000.

Behaviour:
- Reset (rst_n low at a rising edge): issue stage empty, buffer empty, pointers 0, issue_count=0. rsp_valid=0, rsp_data=0, rsp_zero=0, rsp_tag=0, req_ready=0 during reset, and 1 on the first cycle after reset deasserts.
- Reset mid-operation discards the issue stage and all buffered results with no partial output.
- Issue stage: one register set {a,b,op,tag,valid}. A request is accepted on a cycle with req_valid && req_ready.
- req_ready = !issue_valid || (buffer not full) || (buffer full && rsp_ready this cycle). It is combinational from state and rsp_ready, never from req_valid.
- The `alu` is instantiated on the issue registers. When issue_valid is set and the buffer has room (same rule as above), {ALU_Out, ZF, tag} is written into the buffer at the write pointer.
- The issue stage frees on that edge and reloads on the same edge if a new request is accepted. Full throughput is 1 op/cycle.
- Latency: accepted at edge N, result visible on rsp_* after edge N+1 (rsp_valid high the following cycle when the buffer was empty).
- Buffer: 2 entries, read/write pointers plus count (0..2). rsp_* show the head entry combinationally. When empty, rsp_data/zero/tag = 0.
- Simultaneous buffer write and read when count=2: the write is allowed and the count stays 2. When count=0, a write and a read cannot coincide because rsp_valid=0.
- Pointers wrap 1->0.
- Backpressure: with rsp_ready held low, exactly 3 requests are accepted (2 buffered + 1 in issue); req_ready then drops. Nothing is dropped or reordered.
- issue_count increments by 1 on each buffer write.
- Results leave in request order. Operands are never re-sampled after acceptance.

Decomposition:
- Shared package `risc_pkg`: DATA_W=16, OP_W=3, and ALU op constants used by benches (ALU_OP_SUB=3'd1 at minimum).
- Sub-modules: the existing `alu` instance, plus one natural sub-module `rsp_fifo2` holding the 2-entry result buffer, pointers and count.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with req_valid=1 -> req_ready=0, rsp_valid=0, issue_count=0, no acceptance.
- Zero flag: req A=16'h8008, B=16'h8008, op=SUB, tag=5, rsp_ready=1 -> two cycles later rsp_valid=1, rsp_data=0, rsp_zero=1, rsp_tag=5.
- Nonzero: A=5, B=3, op=SUB, tag=2 -> rsp_data=2, rsp_zero=0, rsp_tag=2. Additionally, sweep ops 0..7 with A=16'h8008, B=3 -> rsp_data/rsp_zero equal a direct `alu` reference instance.
- Backpressure: rsp_ready=0, stream tags 1..5 back-to-back -> exactly tags 1,2,3 accepted, req_ready=0. Release rsp_ready -> tags 1..5 emerge in order at 1/cycle, issue_count=5.
- Throughput/simultaneous: rsp_ready=1 with continuous requests -> req_ready stays 1, one result per cycle. With buffer full, a read and a write on the same cycle keep count=2.
- Reset mid-stream: 2 results buffered plus 1 in issue, pulse rst_n=0 for one cycle -> rsp_valid=0 next cycle, issue_count=0, no stale tag ever appears.
